// File: rtl/can_msg_fifo.sv
// First-word-fall-through FIFO for CAN frame words with sticky overflow/underflow
// flags, a saturating drop counter and synchronous flush.
module can_msg_fifo #(
   parameter int DATA_WIDTH = 128,
   parameter int MEM_DEPTH  = 4,
   parameter int AFULL_LVL  = MEM_DEPTH - 1,
   parameter int AEMPTY_LVL = 1
) (
   input  logic                         i_sys_clk,
   input  logic                         i_reset_n,
   input  logic                         i_flush,
   input  logic                         i_err_clr,
   input  logic                         i_w_en,
   input  logic [DATA_WIDTH-1:0]        i_w_data,
   input  logic                         i_r_en,
   output logic [DATA_WIDTH-1:0]        o_r_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_almost_full,
   output logic                         o_almost_empty,
   output logic [$clog2(MEM_DEPTH):0]   o_count,
   output logic                         o_overflow,
   output logic                         o_underflow,
   output logic [7:0]                   o_drop_cnt
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]         w_ptr;
   logic [PW-1:0]         r_ptr;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic rd_ok;
   logic wr_ok;
   logic ovf_evt;
   logic unf_evt;

   // Handshake: a request is taken on the rising edge when its enable is high and
   // the matching accept (rd_ok / wr_ok) is high; otherwise it is a rejected event.
   // A write into a full FIFO is taken only if a read pops an entry in the same cycle.
   assign o_empty        = (w_ptr == r_ptr);
   assign o_full         = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
   assign o_count        = w_ptr - r_ptr;
   assign o_almost_full  = (o_count >= PW'(AFULL_LVL));
   assign o_almost_empty = (o_count <= PW'(AEMPTY_LVL));
   assign o_r_data       = o_empty ? '0 : mem[r_ptr[AW-1:0]];

   assign rd_ok   = i_r_en && !o_empty;
   assign wr_ok   = i_w_en && (!o_full || rd_ok);
   // Flush overrides the cycle's requests, so nothing is rejected either.
   assign ovf_evt = i_w_en && !wr_ok && !i_flush;
   assign unf_evt = i_r_en && !rd_ok && !i_flush;

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         w_ptr <= '0;
         r_ptr <= '0;
      end else if (i_flush) begin
         w_ptr <= '0;
         r_ptr <= '0;
      end else begin
         if (wr_ok) w_ptr <= w_ptr + 1'b1;
         if (rd_ok) r_ptr <= r_ptr + 1'b1;
      end
   end

   // Storage is deliberately not reset; stale entries are unreachable behind the pointers.
   always_ff @(posedge i_sys_clk) begin
      if (wr_ok && !i_flush) mem[w_ptr[AW-1:0]] <= i_w_data;
   end

   always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
         o_drop_cnt  <= 8'd0;
      end else begin
         if (ovf_evt)        o_overflow <= 1'b1;
         else if (i_err_clr) o_overflow <= 1'b0;

         if (unf_evt)        o_underflow <= 1'b1;
         else if (i_err_clr) o_underflow <= 1'b0;

         // A clear coinciding with a new drop restarts the count at one.
         if (ovf_evt) begin
            if (i_err_clr)                o_drop_cnt <= 8'd1;
            else if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
         end else if (i_err_clr) begin
            o_drop_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_can_msg_fifo.sv
// Self-checking bench for can_msg_fifo: queue-based reference model with a
// scoreboard of expected head words, plus directed fill/drain/flush/reset cases.
module tb_can_msg_fifo;

   localparam int DW = 128;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          err_clr;
   logic          w_en;
   logic [DW-1:0] w_data;
   logic          r_en;
   logic [DW-1:0] r_data;
   logic          full, empty, afull, aempty;
   logic [2:0]    count;
   logic          ovf, unf;
   logic [7:0]    drop;

   logic [DW-1:0] exp_q[$];
   logic          m_ovf;
   logic          m_unf;
   int            m_drop;
   int            n_checks;
   int            n_errors;

   can_msg_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
      .i_sys_clk      (clk),
      .i_reset_n      (rst_n),
      .i_flush        (flush),
      .i_err_clr      (err_clr),
      .i_w_en         (w_en),
      .i_w_data       (w_data),
      .i_r_en         (r_en),
      .o_r_data       (r_data),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (afull),
      .o_almost_empty (aempty),
      .o_count        (count),
      .o_overflow     (ovf),
      .o_underflow    (unf),
      .o_drop_cnt     (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_status(input string tag);
      int n;
      n = exp_q.size();
      check({tag, ".count"},  DW'(count),  DW'(n));
      check({tag, ".empty"},  DW'(empty),  DW'(n == 0));
      check({tag, ".full"},   DW'(full),   DW'(n == DEPTH));
      check({tag, ".afull"},  DW'(afull),  DW'(n >= DEPTH - 1));
      check({tag, ".aempty"}, DW'(aempty), DW'(n <= 1));
      check({tag, ".ovf"},    DW'(ovf),    DW'(m_ovf));
      check({tag, ".unf"},    DW'(unf),    DW'(m_unf));
      check({tag, ".drop"},   DW'(drop),   DW'(m_drop));
      check({tag, ".head"},   r_data,      (n == 0) ? '0 : exp_q[0]);
   endtask

   // One clock of stimulus: model the cycle, compare the popped head, then check status.
   task automatic step(input string tag, input logic we, input logic [DW-1:0] wd,
                       input logic re, input logic fl, input logic ec);
      bit rd_acc, wr_acc, ovf_e, unf_e;
      logic [DW-1:0] exp_head;
      w_en = we; w_data = wd; r_en = re; flush = fl; err_clr = ec;
      #1;
      rd_acc = re && exp_q.size() > 0;
      wr_acc = we && (exp_q.size() < DEPTH || rd_acc);
      ovf_e  = we && !wr_acc && !fl;
      unf_e  = re && !rd_acc && !fl;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (rd_acc) begin
            exp_head = exp_q.pop_front();
            check({tag, ".rdata"}, r_data, exp_head);
         end
         if (wr_acc) exp_q.push_back(wd);
      end
      if (ovf_e) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
      if (unf_e) m_unf = 1'b1; else if (ec) m_unf = 1'b0;
      if (ovf_e) m_drop = ec ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      else if (ec) m_drop = 0;
      @(posedge clk);
      #1;
      w_en = 1'b0; r_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
      check_status(tag);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_drop = 0;
   endtask

   logic [DW-1:0] a [5];

   initial begin
      n_checks = 0; n_errors = 0;
      flush = 0; err_clr = 0; w_en = 0; w_data = '0; r_en = 0;
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check_status("reset");

      // Fill, overflow, drain.
      for (int i = 0; i < 5; i++) a[i] = rnd_word();
      for (int i = 0; i < 5; i++) step("fill", 1'b1, a[i], 1'b0, 1'b0, 1'b0);
      check("fill.ovf_set", DW'(ovf), DW'(1));
      check("fill.drop1", DW'(drop), DW'(1));
      for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("drain.zero", r_data, '0);
      step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Read and write together while full.
      for (int i = 0; i < 4; i++) step("bfill", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
      step("rw_full", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
      check("rw_full.noovf", DW'(ovf), DW'(0));
      for (int i = 0; i < 4; i++) step("bdrain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Read and write together while empty.
      step("rw_empty", 1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
      check("rw_empty.unf", DW'(unf), DW'(1));

      // Flush with a concurrent write; sticky state untouched.
      for (int i = 0; i < 2; i++) step("pre_flush", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
      step("flush", 1'b1, rnd_word(), 1'b0, 1'b1, 1'b0);
      check("flush.empty", DW'(empty), DW'(1));

      // Drop counter saturation, then clear coinciding with a drop.
      for (int i = 0; i < 4; i++) step("sfill", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step("sat", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
      check("sat.drop255", DW'(drop), DW'(255));
      step("clr_drop", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b1);
      check("clr_drop.drop1", DW'(drop), DW'(1));

      // Random traffic.
      for (int i = 0; i < 300; i++)
         step("rand", 1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 15) == 0));

      // Asynchronous reset between edges with two entries and underflow set.
      step("pre_rst_flush", 1'b0, '0, 1'b0, 1'b1, 1'b1);
      step("pre_rst_unf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("pre_rst", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("arst.empty", DW'(empty), DW'(1));
      check("arst.count", DW'(count), DW'(0));
      check("arst.unf",   DW'(unf),   DW'(0));
      check_status("arst");
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      step("post_rst", 1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
      step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/can_msg_fifo.md
CAN_MSG_FIFO -- requirements
Module: can_msg_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: width of each stored CAN frame word.
REQ-002 SHALL have parameter MEM_DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 SHALL have parameter AFULL_LVL, default MEM_DEPTH-1: count at or above which almost-full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 1: count at or below which almost-empty asserts.
REQ-005 SHALL have the port i_sys_clk  in  1  system clock; the only clock, all logic on its rising edge.
REQ-006 SHALL have the port i_reset_n  in  1  reset: asynchronous assert, active-low.
REQ-007 SHALL have the port i_flush  in  1  synchronous discard of all stored entries.
REQ-008 SHALL have the port i_err_clr  in  1  synchronous clear of sticky error flags and the drop counter.
REQ-009 SHALL have the port i_w_en  in  1  write request.
REQ-010 SHALL have the port i_w_data  in  DATA_WIDTH  write data.
REQ-011 SHALL have the port i_r_en  in  1  read request; pops the head entry.
REQ-012 SHALL have the port o_r_data  out  DATA_WIDTH  head entry, first-word-fall-through.
REQ-013 SHALL have the ports o_full, o_empty, o_almost_full and o_almost_empty, each  out  1  status flag.
REQ-014 SHALL have the port o_count  out  $clog2(MEM_DEPTH)+1  current number of stored entries.
REQ-015 SHALL have the ports o_overflow and o_underflow, each  out  1  sticky error flag.
REQ-016 SHALL have the port o_drop_cnt  out  8  saturating count of rejected writes.

Function
REQ-017 SHALL derive all status outputs combinationally from pointer/count registers, with no extra register stage on them.
- Pointers: $clog2(MEM_DEPTH)+1 bits wide; MSB is the wrap bit.
- o_empty = (w_ptr == r_ptr).
- o_full = wrap bits differ and index bits are equal.
- o_count = w_ptr - r_ptr, modulo the pointer width.
- o_almost_full = (o_count >= AFULL_LVL).
- o_almost_empty = (o_count <= AEMPTY_LVL).
REQ-018 SHALL drive o_r_data with memory[r_ptr index] when not empty, and with all zeros when empty.
- o_r_data is valid in the same cycle o_empty deasserts, with zero read latency.
REQ-019 SHALL accept a write when i_w_en=1 and either o_full=0, or o_full=1 and a read is accepted in the same cycle.
- On acceptance: store the data at the w_ptr index and increment w_ptr.
- This same-cycle read+write while full is new behaviour; count stays at MEM_DEPTH.
REQ-020 SHALL accept a read when i_r_en=1 and o_empty=0, and increment r_ptr.
- A same-cycle write to an empty FIFO is accepted; the read is rejected.
REQ-021 SHALL treat a rejected write as an overflow event and a rejected read as an underflow event.
- Rejected requests change no pointer or memory state.
REQ-022 SHALL set o_overflow or o_underflow on the clock edge after the event.
- The flag stays at 1 until i_err_clr=1 or reset.
- If i_err_clr and a new event fall in the same cycle, the flag SHALL be 1 afterwards (set wins).
REQ-023 SHALL increment o_drop_cnt by 1 on each overflow event, saturating at 255.
- i_err_clr clears it to 0.
- If i_err_clr coincides with an overflow event, the result SHALL be 1.
REQ-024 SHALL, on i_flush=1, set both pointers to 0 on the next edge, overriding any read or write in that cycle.
- A flush raises no error event.
- A flush does not alter sticky flags or o_drop_cnt.
- Memory contents are left as they are.
REQ-025 SHALL wrap pointers modulo 2*MEM_DEPTH; the index uses the low $clog2(MEM_DEPTH) bits.

Reset
REQ-026 SHALL, while i_reset_n=0, asynchronously force these values:
- pointers = 0.
- o_overflow = 0, o_underflow = 0, o_drop_cnt = 0.
- Resulting outputs: o_empty=1, o_full=0, o_count=0, o_almost_empty=1, o_almost_full=0, o_r_data=0.
REQ-027 SHALL NOT reset memory contents; entries are unreachable until rewritten.
REQ-028 SHALL abandon any operation in progress when reset asserts mid-operation, and resume normal operation on the first rising edge after i_reset_n returns to 1.

Verification
REQ-029 SHALL cover fill and drain with MEM_DEPTH=4:
- Stimulus: write A1..A4, then write A5.
- Expected: o_full=1, o_count=4, o_almost_full=1.
- Expected after A5: o_overflow=1, o_drop_cnt=1.
- Then read 4 times. Expected: o_r_data A1, A2, A3, A4 in order, then o_empty=1 and o_r_data=0.
REQ-030 SHALL cover simultaneous read and write while full:
- Stimulus: with B1..B4 stored, assert i_w_en(B5) and i_r_en together.
- Expected: o_count stays 4, o_overflow stays 0, head becomes B2.
- Then drain. Expected: B2, B3, B4, B5.
REQ-031 SHALL cover simultaneous read and write while empty:
- Stimulus: on an empty FIFO, assert i_w_en(C1) and i_r_en together.
- Expected next cycle: o_count=1, o_r_data=C1, o_underflow=1.
REQ-032 SHALL cover flush:
- Stimulus: with 3 entries stored, assert i_flush and i_w_en together.
- Expected next cycle: o_empty=1, o_count=0.
- Expected: sticky flags and o_drop_cnt unchanged.
REQ-033 SHALL cover drop-counter saturation and clear:
- Stimulus: 300 writes while full.
- Expected: o_drop_cnt=255.
- Stimulus: i_err_clr together with one more rejected write.
- Expected: o_drop_cnt=1, o_overflow=1.
REQ-034 SHALL cover asynchronous reset mid-operation:
- Stimulus: with 2 entries and o_underflow=1, assert i_reset_n=0 between clock edges.
- Expected, immediately and without a clock edge: o_empty=1, o_count=0, o_underflow=0.
